ex_arith_stage: RTL and testbench

Execute-stage arithmetic front end of the pipelined core. Sits between the ID/EX register and the EX/MEM register, and wraps the combinational `arithm` unit. Single-cycle ADD/SUB/MUL_L/MUL_H pass straight through `arithm`. DIV/REM run on an internal WIDTH-cycle restoring divider instead of the combinational `/` and `%`, and the block stalls upstream while the divider is busy. Results and flags are registered behind a valid/ready handshake toward EX/MEM.

---
 rtl/ex_arith_stage_pkg.sv | 24 ++
 rtl/arithm.sv | 59 +++++
 rtl/ex_arith_stage_div_iter.sv | 62 ++++++
 rtl/ex_arith_stage.sv | 135 +++++++++++++
 tb/tb_ex_arith_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_arith_stage_pkg.sv
// Shared definitions for the execute-stage arithmetic front end:
// operand width, arithmetic op encodings and divider FSM states.
package ex_arith_stage_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_MUL_L = 3'b010;
    localparam logic [2:0] ALU_MUL_H = 3'b011;
    localparam logic [2:0] ALU_DIV   = 3'b100;
    localparam logic [2:0] ALU_REM   = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [2:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_REM);
    endfunction

endpackage

// File: rtl/arithm.sv
// Combinational arithmetic unit: unsigned add/sub with carry and overflow,
// low/high multiply, divide and remainder.
// Ports: arithm_sel, first_op, second_op in; o_data, ovf, cf out.
module arithm
    import ex_arith_stage_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic [2:0]       arithm_sel,
    input  logic [WIDTH-1:0] first_op,
    input  logic [WIDTH-1:0] second_op,
    output logic [WIDTH-1:0] o_data,
    output logic             ovf,
    output logic             cf
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic               a_msb;
    logic               b_msb;

    assign sum   = {1'b0, first_op} + {1'b0, second_op};
    assign diff  = {1'b0, first_op} - {1'b0, second_op};
    assign prod  = {{WIDTH{1'b0}}, first_op} * {{WIDTH{1'b0}}, second_op};
    assign a_msb = first_op[WIDTH-1];
    assign b_msb = second_op[WIDTH-1];

    always_comb begin
        o_data = '0;
        ovf    = 1'b0;
        cf     = 1'b0;
        case (arithm_sel)
            ALU_ADD: begin
                o_data = sum[WIDTH-1:0];
                cf     = sum[WIDTH];
                ovf    = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
            end
            ALU_SUB: begin
                o_data = diff[WIDTH-1:0];
                // Carry is the inverted borrow (ARM-style).
                cf     = ~diff[WIDTH];
                ovf    = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
            end
            ALU_MUL_L: o_data = prod[WIDTH-1:0];
            ALU_MUL_H: o_data = prod[2*WIDTH-1:WIDTH];
            ALU_DIV: begin
                if (second_op == '0) o_data = '1;
                else                 o_data = first_op / second_op;
            end
            ALU_REM: begin
                if (second_op == '0) o_data = first_op;
                else                 o_data = first_op % second_op;
            end
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/ex_arith_stage_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH steps.
// Ports: start/dividend/divisor in; quotient, remainder, done (last step) out.
module div_iter
    import ex_arith_stage_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // Shifted remainder keeps the bit that falls off the top, so divisors
    // with the MSB set still compare correctly.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             fits;

    assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign fits    = rem_sh >= {1'b0, dvs_q};

    // Quotient bits shift into the vacated low end of the dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= CNT_W'(WIDTH - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], fits};
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = dvd_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_arith_stage.sv
// Execute-stage arithmetic front end: single-cycle ops via arithm, DIV/REM
// via an iterative divider; registered result behind valid/ready.
// Ports: clk, rst; in_valid/in_ready, arithm_sel, first_op, second_op, in_rd;
// out_valid/out_ready, o_data, ovf, cf, out_rd; busy.
module ex_arith_stage
    import ex_arith_stage_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       arithm_sel,
    input  logic [WIDTH-1:0] first_op,
    input  logic [WIDTH-1:0] second_op,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             ovf,
    output logic             cf,
    output logic [RD_W-1:0]  out_rd,
    output logic             busy
);

    div_state_e       state_q;
    div_state_e       state_d;

    logic [WIDTH-1:0] alu_data;
    logic             alu_ovf;
    logic             alu_cf;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             div_done;

    logic             accept;
    logic             is_div;
    logic             div_zero;
    logic             div_start;
    logic             load_fast;
    logic             flags_ok;
    logic [WIDTH-1:0] fast_data;

    logic [RD_W-1:0]  tag_q;
    logic             rem_sel_q;

    arithm #(.WIDTH(WIDTH)) u_arithm (
        .arithm_sel (arithm_sel),
        .first_op   (first_op),
        .second_op  (second_op),
        .o_data     (alu_data),
        .ovf        (alu_ovf),
        .cf         (alu_cf)
    );

    assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_div    = is_div_op(arithm_sel);
    assign div_zero  = second_op == '0;
    assign div_start = accept && is_div && !div_zero;
    // Divide-by-zero is resolved through the single-cycle path.
    assign load_fast = accept && !(is_div && !div_zero);
    assign flags_ok  = arithm_sel[2:1] == 2'b00;
    assign busy      = state_q != IDLE;

    always_comb begin
        fast_data = alu_data;
        if (is_div) fast_data = (arithm_sel == ALU_DIV) ? '1 : first_op;
    end

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (first_op),
        .divisor   (second_op),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (div_start) state_d = DIV_RUN;
            DIV_RUN:  if (div_done)  state_d = DIV_DONE;
            DIV_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            rem_sel_q <= 1'b0;
        end else if (div_start) begin
            tag_q     <= in_rd;
            rem_sel_q <= arithm_sel == ALU_REM;
        end
    end

    // The output slot was free when the divide was accepted, so DIV_DONE
    // never collides with a pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            o_data    <= '0;
            ovf       <= 1'b0;
            cf        <= 1'b0;
            out_rd    <= '0;
        end else if (load_fast) begin
            out_valid <= 1'b1;
            o_data    <= fast_data;
            ovf       <= flags_ok && alu_ovf;
            cf        <= flags_ok && alu_cf;
            out_rd    <= in_rd;
        end else if (state_q == DIV_DONE) begin
            out_valid <= 1'b1;
            o_data    <= rem_sel_q ? rem : quo;
            ovf       <= 1'b0;
            cf        <= 1'b0;
            out_rd    <= tag_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_arith_stage.sv
// Directed testbench for ex_arith_stage.
// Drives inputs 1ns after posedge and samples 1ns after posedge.
module tb_ex_arith_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  arithm_sel;
    logic [31:0] first_op;
    logic [31:0] second_op;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o_data;
    logic        ovf;
    logic        cf;
    logic [4:0]  out_rd;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_arith_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .arithm_sel (arithm_sel),
        .first_op   (first_op),
        .second_op  (second_op),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .o_data     (o_data),
        .ovf        (ovf),
        .cf         (cf),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid   = 1'b1;
        arithm_sel = sel;
        first_op   = a;
        second_op  = b;
        in_rd      = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        arithm_sel = 3'b000; first_op = '0; second_op = '0; in_rd = '0;
        step(); step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, o_data, ovf, cf, out_rd, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got v=%b d=%h o=%b c=%b rd=%0d b=%b want all 0",
                     out_valid, o_data, ovf, cf, out_rd, busy);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step();
    endtask

    task automatic test_add_ovf();
        drive(3'b000, 32'h7FFF_FFFF, 32'h1, 5'd1);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, o_data, ovf, cf} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf: got v=%b d=%h o=%b c=%b want v=1 d=80000000 o=1 c=0",
                     out_valid, o_data, ovf, cf);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pulse: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(3'b001, 32'd5, 32'd7, 5'd2);
        step();
        n_cmp++;
        if ({out_valid, o_data, cf, ovf} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub: got v=%b d=%h c=%b o=%b want v=1 d=fffffffe c=0 o=0",
                     out_valid, o_data, cf, ovf);
        end
        drive(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd4);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, o_data, cf, ovf, out_rd} !== {1'b1, 32'h1, 1'b0, 1'b0, 5'd4}) begin
            n_fail++;
            $display("FAIL mulh: got v=%b d=%h c=%b o=%b rd=%0d want v=1 d=1 c=0 o=0 rd=4",
                     out_valid, o_data, cf, ovf, out_rd);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_div();
        int bad;
        int got;
        drive(3'b100, 32'd100, 32'd7, 5'd3);
        step();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; bad++;
                if (bad < 4)
                    $display("FAIL div_busy[%0d]: got busy=%b in_ready=%b v=%b want 1 0 0",
                             i, busy, in_ready, out_valid);
            end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL div_early: got out_valid=%b want 0", out_valid);
        end
        step();
        n_cmp++;
        if ({out_valid, o_data, out_rd, ovf, cf, busy} !==
            {1'b1, 32'd14, 5'd3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div_result: got v=%b d=%0d rd=%0d o=%b c=%b b=%b want 1 14 3 0 0 0",
                     out_valid, o_data, out_rd, ovf, cf, busy);
        end
        step();
        drive(3'b101, 32'd100, 32'd7, 5'd9);
        step();
        in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step();
            if (out_valid === 1'b1) got = 1;
        end
        n_cmp++;
        if (got == 0 || o_data !== 32'd2 || out_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL rem_result: got seen=%0d d=%0d rd=%0d want seen=1 d=2 rd=9",
                     got, o_data, out_rd);
        end
        step();
    endtask

    task automatic test_div_zero();
        drive(3'b100, 32'd9, 32'd0, 5'd6);
        step();
        n_cmp++;
        if ({out_valid, o_data, ovf, cf, busy} !== {1'b1, 32'hFFFF_FFFF, 3'b000}) begin
            n_fail++;
            $display("FAIL div0: got v=%b d=%h o=%b c=%b b=%b want 1 ffffffff 0 0 0",
                     out_valid, o_data, ovf, cf, busy);
        end
        drive(3'b101, 32'd9, 32'd0, 5'd7);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, o_data, busy, out_rd} !== {1'b1, 32'd9, 1'b0, 5'd7}) begin
            n_fail++;
            $display("FAIL rem0: got v=%b d=%0d b=%b rd=%0d want 1 9 0 7",
                     out_valid, o_data, busy, out_rd);
        end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(3'b000, 32'd3, 32'd4, 5'd5);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, o_data, in_ready, out_rd} !== {1'b1, 32'd7, 1'b0, 5'd5}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b d=%0d ir=%b rd=%0d want 1 7 0 5",
                         i, out_valid, o_data, in_ready, out_rd);
            end
            step();
        end
        drive(3'b000, 32'd10, 32'd20, 5'd8);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, o_data, out_rd} !== {1'b1, 32'd30, 5'd8}) begin
            n_fail++;
            $display("FAIL drain_load: got v=%b d=%0d rd=%0d want 1 30 8",
                     out_valid, o_data, out_rd);
        end
        step();
    endtask

    task automatic test_reset_mid_div();
        int seen;
        drive(3'b100, 32'd100, 32'd7, 5'd3);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, o_data, ovf, cf, out_rd, busy} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_div: got v=%b d=%h b=%b ir=%b want 0 0 0 1",
                     out_valid, o_data, busy, in_ready);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_discard: got %0d cycles with valid/busy want 0", seen);
        end
        drive(3'b000, 32'd1, 32'd1, 5'd1);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, o_data, out_rd} !== {1'b1, 32'd2, 5'd1}) begin
            n_fail++;
            $display("FAIL post_rst_add: got v=%b d=%0d rd=%0d want 1 2 1",
                     out_valid, o_data, out_rd);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
